bft_stream_packetizer: RTL and testbench

- Source-side endpoint of the BFT leaf protocol. Takes one 32-bit valid/ack user stream and emits 49-bit BFT packets addressed to a fixed destination leaf and port.
- Tracks receiver buffer space with a credit counter. Credits are replenished by freespace-update packets returned over the BFT.
- Sits between a stream producer (DMA or user kernel) and the BFT switch port. It is the transmitting counterpart of a leaf's input-port receive buffers.

---
 rtl/bft_stream_packetizer_if.sv | 33 +++
 rtl/bft_stream_packetizer.sv | 131 +++++++++++++
 tb/tb_bft_stream_packetizer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bft_stream_packetizer_if.sv
`default_nettype none
// ============================================================================
// bft_stream_packetizer_if : user stream and BFT packet signals of the packetizer
// Revision: 1.0
// ============================================================================
interface bft_stream_packetizer_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PACKET_BITS  = 49
);
  logic [PAYLOAD_BITS-1:0] din_user2packetizer;
  logic                    vld_user2packetizer;
  logic                    ack_packetizer2user;
  logic [PACKET_BITS-1:0]  dout_packetizer2bft;
  logic [PACKET_BITS-1:0]  din_bft2packetizer;

  // Environment side: stream producer plus the BFT switch port
  modport master (
    output din_user2packetizer,
    output vld_user2packetizer,
    output din_bft2packetizer,
    input  ack_packetizer2user,
    input  dout_packetizer2bft
  );

  modport slave (
    input  din_user2packetizer,
    input  vld_user2packetizer,
    input  din_bft2packetizer,
    output ack_packetizer2user,
    output dout_packetizer2bft
  );
endinterface
`default_nettype wire

// File: rtl/bft_stream_packetizer.sv
`default_nettype none
// ============================================================================
// bft_stream_packetizer : user stream to BFT packets with credit flow control
// Revision: 1.0
// ============================================================================
module bft_stream_packetizer #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int SELF_LEAF          = 0
) (
  input  wire                          clk,
  input  wire                          reset_n,
  input  wire                          ap_start,
  input  wire [NUM_LEAF_BITS-1:0]      dest_leaf,
  input  wire [NUM_PORT_BITS-1:0]      dest_port,
  input  wire                          resend,
  output logic [NUM_BRAM_ADDR_BITS:0]  credit_count,
  output logic                         credit_overflow,
  bft_stream_packetizer_if.slave       bus
);

  localparam int c_credit_w = NUM_BRAM_ADDR_BITS + 1;
  localparam int c_port_lsb = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int c_leaf_lsb = c_port_lsb + NUM_PORT_BITS;
  localparam int c_vld_bit  = PACKET_BITS - 1;
  localparam logic [c_credit_w-1:0] c_full = c_credit_w'(1 << NUM_BRAM_ADDR_BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_ack;
  logic                       w_xfer;
  logic                       w_reload;
  logic                       w_ret_hit;
  logic [c_credit_w:0]        w_credit_sum;
  logic [c_credit_w-1:0]      r_credit;
  logic                       r_overflow;
  logic [NUM_ADDR_BITS-1:0]   r_addr;
  logic [NUM_LEAF_BITS-1:0]   r_dest_leaf;
  logic [NUM_PORT_BITS-1:0]   r_dest_port;
  logic [PACKET_BITS-1:0]     r_dout;
  logic                       w_unused_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    case (r_state)
      ST_IDLE: if (ap_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (resend)   w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!resend) begin
          w_state_nxt = ST_RUN;
          w_reload    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ack  = (r_state == ST_RUN) && !resend && (r_credit != '0);
    w_xfer = bus.vld_user2packetizer && w_ack;
  end

  // Credit returns are dropped while resyncing; the HOLD exit reloads anyway
  assign w_ret_hit = bus.din_bft2packetizer[c_vld_bit]
                  && (bus.din_bft2packetizer[c_leaf_lsb +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF))
                  && (bus.din_bft2packetizer[c_port_lsb +: NUM_PORT_BITS] == '0)
                  && (r_state != ST_HOLD) && !resend;

  assign w_credit_sum = {1'b0, r_credit}
                      - (c_credit_w+1)'(w_xfer)
                      + (w_ret_hit ? {1'b0, bus.din_bft2packetizer[NUM_BRAM_ADDR_BITS:0]}
                                   : '0);

  assign w_unused_bits = ^bus.din_bft2packetizer[c_port_lsb-1:NUM_BRAM_ADDR_BITS+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credit    <= c_full;
      r_overflow  <= 1'b0;
      r_addr      <= '0;
      r_dest_leaf <= '0;
      r_dest_port <= '0;
      r_dout      <= '0;
    end else begin
      if ((r_state == ST_IDLE) && ap_start) begin
        r_dest_leaf <= dest_leaf;
        r_dest_port <= dest_port;
      end

      if (w_reload) begin
        r_credit <= c_full;
        r_addr   <= '0;
      end else begin
        if (w_credit_sum > {1'b0, c_full}) begin
          r_credit   <= c_full;
          r_overflow <= 1'b1;
        end else begin
          r_credit <= w_credit_sum[c_credit_w-1:0];
        end
        if (w_xfer) r_addr <= r_addr + 1'b1;
      end

      r_dout <= w_xfer ? {1'b1, r_dest_leaf, r_dest_port, r_addr, bus.din_user2packetizer}
                       : '0;
    end
  end

  // resend kills the scheduled packet in the cycle it would appear
  assign bus.dout_packetizer2bft = resend ? '0 : r_dout;
  assign bus.ack_packetizer2user = w_ack;
  assign credit_count            = r_credit;
  assign credit_overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bft_stream_packetizer.sv
`default_nettype none
// ============================================================================
// tb_bft_stream_packetizer : scoreboard bench for bft_stream_packetizer
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bft_stream_packetizer;

  localparam int SELF = 0;
  localparam int FULL = 128;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        resend = 1'b0;
  logic [4:0]  dest_leaf = '0;
  logic [3:0]  dest_port = '0;
  logic [7:0]  credit_count;
  logic        credit_overflow;

  bft_stream_packetizer_if #(.PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

  bft_stream_packetizer #(
    .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5), .NUM_PORT_BITS(4),
    .NUM_ADDR_BITS(7), .NUM_BRAM_ADDR_BITS(7), .SELF_LEAF(SELF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ap_start(ap_start),
    .dest_leaf(dest_leaf), .dest_port(dest_port), .resend(resend),
    .credit_count(credit_count), .credit_overflow(credit_overflow),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {M_IDLE, M_RUN, M_HOLD} mstate_t;
  mstate_t     m_state;
  int          m_credit;
  logic [6:0]  m_addr;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  logic [48:0] sb[$];
  logic [48:0] mon_exp;
  bit          mon_req = 1'b0;
  bit          exp_ack = 1'b0;

  // Scoreboard: packet queued at transfer appears in the following cycle
  always @(negedge clk) begin
    if (mon_req) begin
      mon_exp = '0;
      if (sb.size() > 0) mon_exp = sb.pop_front();
      if (resend) mon_exp = '0;
      n_cmp++;
      if (bus.dout_packetizer2bft !== mon_exp) begin
        n_err++;
        $display("FAIL sb_dout: got %h expected %h", bus.dout_packetizer2bft, mon_exp);
      end
      n_cmp++;
      if (bus.ack_packetizer2user !== exp_ack) begin
        n_err++;
        $display("FAIL sb_ack: got %b expected %b", bus.ack_packetizer2user, exp_ack);
      end
    end
  end

  task automatic model_reset();
    m_state  = M_IDLE;
    m_credit = FULL;
    m_addr   = '0;
    m_leaf   = '0;
    m_port   = '0;
    sb.delete();
  endtask

  // One clock of stimulus; entered and left at posedge+1
  task automatic drive(input bit v, input logic [31:0] d, input logic [48:0] ret, input bit rs);
    bit xfer;
    bit ret_ok;
    int nxt;
    bus.vld_user2packetizer = v;
    bus.din_user2packetizer = d;
    bus.din_bft2packetizer  = ret;
    resend  = rs;
    exp_ack = (m_state == M_RUN) && !rs && (m_credit != 0);
    mon_req = 1'b1;
    @(negedge clk);
    #1;
    mon_req = 1'b0;
    xfer   = v && exp_ack;
    ret_ok = ret[48] && (ret[47:43] == 5'(SELF)) && (ret[42:39] == 4'd0)
          && (m_state != M_HOLD) && !rs;
    if (xfer) begin
      sb.push_back({1'b1, m_leaf, m_port, m_addr, d});
      m_addr = m_addr + 7'd1;
    end
    if (m_state == M_HOLD && !rs) begin
      m_credit = FULL;
      m_addr   = '0;
    end else begin
      nxt = m_credit - int'(xfer) + (ret_ok ? int'(ret[7:0]) : 0);
      if (nxt > FULL) nxt = FULL;
      m_credit = nxt;
    end
    case (m_state)
      M_IDLE: if (ap_start) begin m_state = M_RUN; m_leaf = dest_leaf; m_port = dest_port; end
      M_RUN:  if (rs) m_state = M_HOLD;
      M_HOLD: if (!rs) m_state = M_RUN;
      default: m_state = M_IDLE;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_cmp++; if (bus.dout_packetizer2bft !== 49'd0) begin n_err++; $display("FAIL reset_dout: got %h expected 0", bus.dout_packetizer2bft); end
    n_cmp++; if (bus.ack_packetizer2user !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", bus.ack_packetizer2user); end
    n_cmp++; if (credit_count !== 8'd128) begin n_err++; $display("FAIL reset_credit: got %0d expected 128", credit_count); end
    n_cmp++; if (credit_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", credit_overflow); end
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_packet();
    dest_leaf = 5'd3;
    dest_port = 4'd2;
    ap_start  = 1'b1;
    drive(1'b0, 32'd0, 49'd0, 1'b0);
    ap_start  = 1'b0;
    dest_leaf = 5'd9;
    drive(1'b1, 32'hDEADBEEF, 49'd0, 1'b0);
    n_cmp++; if (bus.dout_packetizer2bft !== {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}) begin n_err++; $display("FAIL first_pkt: got %h expected 1_1900_deadbeef", bus.dout_packetizer2bft); end
    n_cmp++; if (credit_count !== 8'd127) begin n_err++; $display("FAIL first_credit: got %0d expected 127", credit_count); end
  endtask

  task automatic test_credit_exhaust();
    for (int i = 0; i < 200 && m_credit != 0; i++) drive(1'b1, 32'h1000 + i, 49'd0, 1'b0);
    n_cmp++; if (credit_count !== 8'd0) begin n_err++; $display("FAIL exhaust_credit: got %0d expected 0", credit_count); end
    n_cmp++; if (bus.ack_packetizer2user !== 1'b0) begin n_err++; $display("FAIL exhaust_ack: got %b expected 0", bus.ack_packetizer2user); end
    n_cmp++; if (bus.dout_packetizer2bft[38:32] !== 7'd127) begin n_err++; $display("FAIL exhaust_addr: got %0d expected 127", bus.dout_packetizer2bft[38:32]); end
    drive(1'b1, 32'hAAAA0000, {1'b1, 5'(SELF), 4'd0, 7'd0, 32'd64}, 1'b0);
    n_cmp++; if (credit_count !== 8'd64) begin n_err++; $display("FAIL return_credit: got %0d expected 64", credit_count); end
    n_cmp++; if (bus.ack_packetizer2user !== 1'b1) begin n_err++; $display("FAIL return_ack: got %b expected 1", bus.ack_packetizer2user); end
    drive(1'b1, 32'hCAFE0001, 49'd0, 1'b0);
    n_cmp++; if (bus.dout_packetizer2bft[38:32] !== 7'd0) begin n_err++; $display("FAIL wrap_addr: got %0d expected 0", bus.dout_packetizer2bft[38:32]); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 200 && m_credit > 10; i++) drive(1'b1, 32'h2000 + i, 49'd0, 1'b0);
    n_cmp++; if (credit_count !== 8'd10) begin n_err++; $display("FAIL simul_pre: got %0d expected 10", credit_count); end
    drive(1'b1, 32'h5A5A5A5A, {1'b1, 5'(SELF), 4'd0, 7'd0, 32'd64}, 1'b0);
    n_cmp++; if (credit_count !== 8'd73) begin n_err++; $display("FAIL simul_credit: got %0d expected 73", credit_count); end
  endtask

  task automatic test_overflow();
    drive(1'b0, 32'd0, {1'b1, 5'(SELF), 4'd1, 7'd0, 32'd64}, 1'b0);
    drive(1'b0, 32'd0, {1'b1, 5'd7, 4'd0, 7'd0, 32'd64}, 1'b0);
    drive(1'b0, 32'd0, {1'b0, 5'(SELF), 4'd0, 7'd0, 32'd64}, 1'b0);
    n_cmp++; if (credit_count !== 8'd73) begin n_err++; $display("FAIL ignore_credit: got %0d expected 73", credit_count); end
    drive(1'b0, 32'd0, {1'b1, 5'(SELF), 4'd0, 7'd0, 32'd27}, 1'b0);
    n_cmp++; if (credit_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre: got %b expected 0", credit_overflow); end
    n_cmp++; if (credit_count !== 8'd100) begin n_err++; $display("FAIL ovf_100: got %0d expected 100", credit_count); end
    drive(1'b0, 32'd0, {1'b1, 5'(SELF), 4'd0, 7'd0, 32'd64}, 1'b0);
    n_cmp++; if (credit_count !== 8'd128) begin n_err++; $display("FAIL ovf_clamp: got %0d expected 128", credit_count); end
    n_cmp++; if (credit_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", credit_overflow); end
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h3000 + i, 49'd0, 1'b0);
    n_cmp++; if (credit_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", credit_overflow); end
    n_cmp++; if (credit_count !== 8'd124) begin n_err++; $display("FAIL ovf_after: got %0d expected 124", credit_count); end
  endtask

  task automatic test_resend();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h4000 + i, 49'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4100 + i, {1'b1, 5'(SELF), 4'd0, 7'd0, 32'd5}, 1'b1);
      n_cmp++; if (bus.dout_packetizer2bft !== 49'd0) begin n_err++; $display("FAIL resend_dout: got %h expected 0", bus.dout_packetizer2bft); end
      n_cmp++; if (bus.ack_packetizer2user !== 1'b0) begin n_err++; $display("FAIL resend_ack: got %b expected 0", bus.ack_packetizer2user); end
    end
    drive(1'b1, 32'h4200, 49'd0, 1'b0);
    n_cmp++; if (credit_count !== 8'd128) begin n_err++; $display("FAIL resend_credit: got %0d expected 128", credit_count); end
    drive(1'b1, 32'h77777777, 49'd0, 1'b0);
    n_cmp++; if (bus.dout_packetizer2bft[38:32] !== 7'd0) begin n_err++; $display("FAIL resend_addr: got %0d expected 0", bus.dout_packetizer2bft[38:32]); end
    n_cmp++; if (credit_count !== 8'd127) begin n_err++; $display("FAIL resend_after: got %0d expected 127", credit_count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) drive(1'b1, 32'h5000 + i, 49'd0, 1'b0);
    #2;
    reset_n  = 1'b0;
    ap_start = 1'b0;
    #1;
    n_cmp++; if (bus.dout_packetizer2bft !== 49'd0) begin n_err++; $display("FAIL areset_dout: got %h expected 0", bus.dout_packetizer2bft); end
    n_cmp++; if (bus.ack_packetizer2user !== 1'b0) begin n_err++; $display("FAIL areset_ack: got %b expected 0", bus.ack_packetizer2user); end
    n_cmp++; if (credit_count !== 8'd128) begin n_err++; $display("FAIL areset_credit: got %0d expected 128", credit_count); end
    model_reset();
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h6000 + i, 49'd0, 1'b0);
    dest_leaf = 5'd5;
    dest_port = 4'd1;
    ap_start  = 1'b1;
    drive(1'b0, 32'd0, 49'd0, 1'b0);
    ap_start  = 1'b0;
    drive(1'b1, 32'h0BADF00D, 49'd0, 1'b0);
    n_cmp++; if (bus.dout_packetizer2bft !== {1'b1, 5'd5, 4'd1, 7'd0, 32'h0BADF00D}) begin n_err++; $display("FAIL restart_pkt: got %h expected %h", bus.dout_packetizer2bft, {1'b1, 5'd5, 4'd1, 7'd0, 32'h0BADF00D}); end
    drive(1'b0, 32'd0, 49'd0, 1'b0);
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
  endtask

  initial begin
    bus.vld_user2packetizer = 1'b0;
    bus.din_user2packetizer = '0;
    bus.din_bft2packetizer  = '0;
    model_reset();
    test_reset();
    test_first_packet();
    test_credit_exhaust();
    test_simultaneous();
    test_overflow();
    test_resend();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
